// File: rtl/ddr_axi_rd_engine.sv
// ddr_axi_rd_engine: turns one RSTART/RADDR/RLENGTH command into one AXI4 INCR read burst and streams the beats out
// Ports: clk/rstn (sync, active-low); RSTART_REG/RADDR_REG/RLENGTH_REG in, RIDLE_REG out (command side);
//   m_ar* / m_r* AXI read channels; dout_* valid/ready stream; lat_cycles/beat_total/err_flags statistics.
module ddr_axi_rd_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              RSTART_REG,
  input  logic [31:0]       RADDR_REG,
  input  logic [31:0]       RLENGTH_REG,
  output logic              RIDLE_REG,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       lat_cycles,
  output logic [31:0]       beat_total,
  output logic [2:0]        err_flags
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam logic [4:0] MAXN = 5'(MAX_BEATS);
  state_t state_q, state_d;
  logic ridle_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0] arlen_q, idx_q;
  logic [4:0] n_q, n_raw, n_cl;
  logic [31:0] cnt_q, lat_q, beat_q;
  logic [2:0] err_q;
  logic [12:0] end_off;
  logic bad, accept, go, hs, unused_ok;
  assign n_raw = RLENGTH_REG[4:0];
  assign n_cl = n_raw > MAXN ? MAXN : n_raw;
  // a burst must be beat-aligned and must not cross a 4 KB page
  assign end_off = {1'b0, RADDR_REG[11:0]} + {5'd0, n_cl, 3'd0};
  assign bad = (|RADDR_REG[2:0]) || end_off > 13'd4096;
  assign accept = state_q == IDLE && RSTART_REG;
  assign go = accept && n_raw != 5'd0 && !bad;
  assign hs = state_q == DATA && m_rvalid && dout_ready;
  assign unused_ok = ^RLENGTH_REG[31:5];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (RSTART_REG) state_d = go ? ADDR : DONE;
      ADDR: if (m_arready) state_d = DATA;
      DATA: if (hs && m_rlast) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ridle_q <= 1'b1;
      araddr_q <= '0;
      arlen_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      lat_q <= '0;
      beat_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      // idle flag drops on the accept edge and rises one cycle after DONE has passed
      ridle_q <= state_q == IDLE && !accept;
      if (go) begin
        araddr_q <= ADDR_W'(RADDR_REG);
        arlen_q <= {3'd0, n_cl} - 8'd1;
        n_q <= n_cl;
      end
      cnt_q <= accept ? 32'd0 : cnt_q + 32'd1;
      if (state_q == DONE) lat_q <= cnt_q + 32'd1;
      idx_q <= accept ? 8'd0 : idx_q + 8'(hs);
      if (hs) beat_q <= beat_q + 32'd1;
      err_q <= err_q | {accept && n_raw != 5'd0 && (n_raw > MAXN || bad),
                        hs && m_rresp != 2'd0,
                        hs && m_rlast && idx_q != {3'd0, n_q} - 8'd1};
    end
  end
  assign RIDLE_REG = ridle_q;
  assign m_araddr = araddr_q;
  assign m_arlen = arlen_q;
  assign m_arsize = 3'd3;
  assign m_arburst = 2'b01;
  assign m_arvalid = state_q == ADDR;
  assign m_rready = state_q == DATA && dout_ready;
  assign dout_data = m_rdata;
  assign dout_last = m_rlast;
  assign dout_valid = state_q == DATA && m_rvalid;
  assign lat_cycles = lat_q;
  assign beat_total = beat_q;
  assign err_flags = err_q;
endmodule

// File: tb/tb_ddr_axi_rd_engine.sv
// tb_ddr_axi_rd_engine: randomized AXI slave + stream sink around ddr_axi_rd_engine, checked against a command-level model
module tb_ddr_axi_rd_engine;
  logic clk = 0;
  logic rstn = 0;
  logic RSTART_REG = 0;
  logic [31:0] RADDR_REG = 0, RLENGTH_REG = 0;
  logic RIDLE_REG, m_arvalid, m_rready, dout_last, dout_valid;
  logic [31:0] m_araddr, lat_cycles, beat_total;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize, err_flags;
  logic [1:0] m_arburst;
  logic [63:0] dout_data;
  logic m_arready = 0, m_rvalid = 0, m_rlast = 0, dout_ready = 0;
  logic [63:0] m_rdata = 0;
  logic [1:0] m_rresp = 0;
  always #5 clk = ~clk;
  ddr_axi_rd_engine dut (
    .clk(clk), .rstn(rstn), .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RLENGTH_REG(RLENGTH_REG),
    .RIDLE_REG(RIDLE_REG), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .dout_data(dout_data), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .lat_cycles(lat_cycles), .beat_total(beat_total),
    .err_flags(err_flags)
  );
  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, low_cnt = 0, last_cyc = 0, ar_cnt = 0;
  int ar_hold = 0, resp_at = -1, last_at = -1, s_left = 0, s_i = 0, s_n = 0;
  int exp_beats = 0;
  logic [2:0] exp_err = 0;
  bit rv_rand = 0, rdy_rand = 0, r_fire = 0, ar_unstable = 0, ar_pend = 0, ridle_after = 0, timed_out = 0;
  logic [31:0] s_addr = 0, ar_addr = 0, ap_addr = 0;
  logic [7:0] ar_len = 0, ap_len = 0;
  logic [63:0] got[$];
  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, a};
  endfunction
  // command-level reference: n = beats expected on AXI (0 = no burst), lerr = length/alignment error
  function automatic void model(input logic [31:0] a, input logic [31:0] l, output int n, output bit lerr);
    int raw;
    bit bad;
    raw = int'(l[4:0]);
    n = raw > 16 ? 16 : raw;
    bad = (a % 8 != 0) || (int'(a % 4096) + 8 * n > 4096);
    lerr = raw != 0 && (raw > 16 || bad);
    if (raw == 0 || bad) n = 0;
  endfunction
  // monitor: at each negedge, record what the following posedge will accept
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      s_left = 0;
      ar_pend = 0;
    end else begin
      if (RSTART_REG && RIDLE_REG) begin
        acc_cyc = cyc;
        low_cnt = 0;
      end else if (!RIDLE_REG) low_cnt++;
      if (cyc == acc_cyc + 1) ridle_after = RIDLE_REG;
      if (m_arvalid) begin
        if (ar_pend && (m_araddr !== ap_addr || m_arlen !== ap_len)) ar_unstable = 1;
        ar_pend = !m_arready;
        ap_addr = m_araddr;
        ap_len = m_arlen;
      end
      if (m_arvalid && m_arready) begin
        ar_cnt++;
        ar_addr = m_araddr;
        ar_len = m_arlen;
        s_n = last_at >= 0 ? last_at + 1 : int'(m_arlen) + 1;
        s_left = s_n;
        s_i = 0;
        s_addr = m_araddr;
      end
      if (dout_valid && dout_ready) begin
        got.push_back(dout_data);
        if (m_rlast) last_cyc = cyc;
        s_left = m_rlast ? 0 : s_left - 1;
        s_i++;
        r_fire = 1;
      end
    end
  end
  // AXI slave and stream sink, driven just after each posedge
  always @(posedge clk) begin
    #1;
    m_arready = (ar_hold == 0);
    if (m_arvalid && ar_hold > 0) ar_hold--;
    if (s_left == 0) m_rvalid = 0;
    else if (!m_rvalid || r_fire) m_rvalid = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    r_fire = 0;
    m_rdata = pat(s_addr + 32'(8 * s_i));
    m_rlast = s_left > 0 && s_i == s_n - 1;
    m_rresp = (s_left > 0 && s_i == resp_at) ? 2'd2 : 2'd0;
    dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] l, input int poke);
    got.delete();
    ar_cnt = 0;
    ar_unstable = 0;
    last_cyc = 0;
    timed_out = 1;
    @(posedge clk); #1;
    RADDR_REG = a;
    RLENGTH_REG = l;
    RSTART_REG = 1;
    @(posedge clk); #1;
    RADDR_REG = 32'h5000;
    RLENGTH_REG = 32'd4;
    for (int i = 0; i < 400; i++) begin
      RSTART_REG = (i == poke);
      @(negedge clk);
      if (RIDLE_REG) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    RSTART_REG = 0;
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL idle_timeout addr %h: RIDLE_REG 0 after 400 cycles, want 1", a); end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({RIDLE_REG, m_arvalid, m_rready, dout_valid} !== 4'b1000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 1000", {RIDLE_REG, m_arvalid, m_rready, dout_valid}); end
    n_chk++; if (m_araddr !== 0 || m_arlen !== 0) begin n_fail++; $display("FAIL reset_ar: got %h/%h want 0/0", m_araddr, m_arlen); end
    n_chk++; if (lat_cycles !== 0 || beat_total !== 0 || err_flags !== 0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d/%b want 0/0/000", lat_cycles, beat_total, err_flags); end
    n_chk++; if (m_arsize !== 3'd3 || m_arburst !== 2'b01) begin n_fail++; $display("FAIL ar_const: got %0d/%b want 3/01", m_arsize, m_arburst); end
    rstn = 1;
    @(posedge clk); #1;
    n_chk++; if (RIDLE_REG !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: got %b want 1", RIDLE_REG); end
  endtask
  task automatic test_basic;
    int bad;
    ar_hold = 0; rv_rand = 0; rdy_rand = 0; resp_at = -1; last_at = -1;
    run_cmd(32'h1000, 32'd8, -1);
    exp_beats += 8;
    bad = 0;
    foreach (got[i]) if (got[i] !== pat(32'h1000 + 32'(8 * i))) bad++;
    n_chk++; if (ar_cnt !== 1 || ar_addr !== 32'h1000 || ar_len !== 8'd7) begin n_fail++; $display("FAIL t1_ar: got cnt %0d addr %h len %0d want 1 1000 7", ar_cnt, ar_addr, ar_len); end
    n_chk++; if (got.size() !== 8 || bad !== 0) begin n_fail++; $display("FAIL t1_data: got %0d beats %0d bad want 8 beats 0 bad", got.size(), bad); end
    n_chk++; if (beat_total !== 32'(exp_beats) || err_flags !== 3'b000) begin n_fail++; $display("FAIL t1_stats: got %0d/%b want %0d/000", beat_total, err_flags, exp_beats); end
    n_chk++; if (lat_cycles !== 32'd10) begin n_fail++; $display("FAIL t1_lat: got %0d want 10", lat_cycles); end
    n_chk++; if (ridle_after !== 1'b0) begin n_fail++; $display("FAIL t1_ridle_drop: got %b want 0", ridle_after); end
    run_cmd(32'h2000, 32'd1, -1);
    exp_beats += 1;
    n_chk++; if (low_cnt !== 4 || lat_cycles !== 32'd3) begin n_fail++; $display("FAIL one_beat: got low %0d lat %0d want 4 3", low_cnt, lat_cycles); end
    n_chk++; if (beat_total !== 32'(exp_beats)) begin n_fail++; $display("FAIL one_beat_total: got %0d want %0d", beat_total, exp_beats); end
  endtask
  task automatic test_backpressure;
    int n, bad;
    bit lerr;
    logic [31:0] a;
    rv_rand = 1; rdy_rand = 1;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 16);
      a = {16'(k + 16'h0010), 4'($urandom_range(0, 15)), 12'(8 * $urandom_range(0, 512 - n))};
      model(a, 32'(n), n, lerr);
      ar_hold = (k % 2 == 0) ? 5 : $urandom_range(0, 3);
      run_cmd(a, 32'(n), -1);
      exp_beats += n;
      bad = 0;
      foreach (got[i]) if (got[i] !== pat(a + 32'(8 * i))) bad++;
      n_chk++; if (ar_unstable !== 1'b0) begin n_fail++; $display("FAIL t2_ar_stable k%0d: payload changed while stalled", k); end
      n_chk++; if (ar_cnt !== 1 || ar_addr !== a || ar_len !== 8'(n - 1)) begin n_fail++; $display("FAIL t2_ar k%0d: got %0d %h %0d want 1 %h %0d", k, ar_cnt, ar_addr, ar_len, a, n - 1); end
      n_chk++; if (got.size() !== n || bad !== 0) begin n_fail++; $display("FAIL t2_data k%0d: got %0d beats %0d bad want %0d beats 0 bad", k, got.size(), bad, n); end
      n_chk++; if (beat_total !== 32'(exp_beats) || err_flags !== exp_err) begin n_fail++; $display("FAIL t2_stats k%0d: got %0d/%b want %0d/%b", k, beat_total, err_flags, exp_beats, exp_err); end
      n_chk++; if (lat_cycles !== 32'(last_cyc - acc_cyc + 1)) begin n_fail++; $display("FAIL t2_lat k%0d: got %0d want %0d", k, lat_cycles, last_cyc - acc_cyc + 1); end
    end
    rv_rand = 0; rdy_rand = 0; ar_hold = 0;
  endtask
  task automatic test_len_err;
    logic [31:0] ta[5] = '{32'h3000, 32'h0FC8, 32'h4FC0, 32'h6004, 32'h7000};
    logic [31:0] tl[5] = '{32'd20, 32'd8, 32'd8, 32'd2, 32'd0};
    int n, bad, el;
    bit lerr;
    for (int k = 0; k < 5; k++) begin
      model(ta[k], tl[k], n, lerr);
      if (lerr) exp_err[2] = 1'b1;
      run_cmd(ta[k], tl[k], -1);
      exp_beats += n;
      el = n == 0 ? 1 : last_cyc - acc_cyc + 1;
      bad = 0;
      foreach (got[i]) if (got[i] !== pat(ta[k] + 32'(8 * i))) bad++;
      n_chk++; if (ar_cnt !== (n > 0 ? 1 : 0) || (n > 0 && ar_len !== 8'(n - 1))) begin n_fail++; $display("FAIL t3_ar %h: got cnt %0d len %0d want %0d %0d", ta[k], ar_cnt, ar_len, n > 0, n - 1); end
      n_chk++; if (got.size() !== n || bad !== 0) begin n_fail++; $display("FAIL t3_data %h: got %0d beats %0d bad want %0d", ta[k], got.size(), bad, n); end
      n_chk++; if (err_flags !== exp_err || beat_total !== 32'(exp_beats)) begin n_fail++; $display("FAIL t3_stats %h: got %b/%0d want %b/%0d", ta[k], err_flags, beat_total, exp_err, exp_beats); end
      n_chk++; if (lat_cycles !== 32'(el) || low_cnt !== el + 1) begin n_fail++; $display("FAIL t3_timing %h: got lat %0d low %0d want %0d %0d", ta[k], lat_cycles, low_cnt, el, el + 1); end
    end
  endtask
  task automatic test_resp_last;
    int bad;
    resp_at = 2; last_at = 5;
    run_cmd(32'h8000, 32'd8, -1);
    exp_beats += 6;
    exp_err[1:0] = 2'b11;
    bad = 0;
    foreach (got[i]) if (got[i] !== pat(32'h8000 + 32'(8 * i))) bad++;
    n_chk++; if (got.size() !== 6 || bad !== 0) begin n_fail++; $display("FAIL t4_data: got %0d beats %0d bad want 6 beats", got.size(), bad); end
    n_chk++; if (err_flags !== exp_err || beat_total !== 32'(exp_beats)) begin n_fail++; $display("FAIL t4_stats: got %b/%0d want %b/%0d", err_flags, beat_total, exp_err, exp_beats); end
    resp_at = -1; last_at = 4;
    run_cmd(32'h8100, 32'd4, -1);
    exp_beats += 5;
    n_chk++; if (got.size() !== 5 || beat_total !== 32'(exp_beats)) begin n_fail++; $display("FAIL late_last: got %0d beats total %0d want 5 %0d", got.size(), beat_total, exp_beats); end
    n_chk++; if (lat_cycles !== 32'(last_cyc - acc_cyc + 1)) begin n_fail++; $display("FAIL late_last_lat: got %0d want %0d", lat_cycles, last_cyc - acc_cyc + 1); end
    last_at = -1;
  endtask
  task automatic test_ignore_start;
    int bad;
    rdy_rand = 1;
    run_cmd(32'h9000, 32'd16, 4);
    exp_beats += 16;
    rdy_rand = 0;
    bad = 0;
    foreach (got[i]) if (got[i] !== pat(32'h9000 + 32'(8 * i))) bad++;
    n_chk++; if (got.size() !== 16 || bad !== 0) begin n_fail++; $display("FAIL t5_data: got %0d beats %0d bad want 16", got.size(), bad); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ar_cnt !== 1 || RIDLE_REG !== 1'b1 || m_arvalid !== 1'b0) begin n_fail++; $display("FAIL t5_ignore: got ar %0d idle %b arvalid %b want 1 1 0", ar_cnt, RIDLE_REG, m_arvalid); end
    n_chk++; if (beat_total !== 32'(exp_beats)) begin n_fail++; $display("FAIL t5_total: got %0d want %0d", beat_total, exp_beats); end
  endtask
  task automatic test_reset_mid;
    @(posedge clk); #1;
    RADDR_REG = 32'hA000; RLENGTH_REG = 32'd16; RSTART_REG = 1;
    @(posedge clk); #1;
    RSTART_REG = 0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (dout_valid !== 1'b1 || RIDLE_REG !== 1'b0) begin n_fail++; $display("FAIL t5_in_data: got valid %b idle %b want 1 0", dout_valid, RIDLE_REG); end
    rstn = 0;
    @(posedge clk); #1;
    n_chk++; if ({RIDLE_REG, m_arvalid, m_rready, dout_valid} !== 4'b1000 || m_araddr !== 0 || m_arlen !== 0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b %h %h want 1000 0 0", {RIDLE_REG, m_arvalid, m_rready, dout_valid}, m_araddr, m_arlen); end
    n_chk++; if (lat_cycles !== 0 || beat_total !== 0 || err_flags !== 0) begin n_fail++; $display("FAIL mid_reset_stats: got %0d/%0d/%b want 0/0/000", lat_cycles, beat_total, err_flags); end
    rstn = 1;
    exp_beats = 0;
    exp_err = 0;
    @(posedge clk); #1;
    run_cmd(32'hB000, 32'd2, -1);
    exp_beats += 2;
    n_chk++; if (got.size() !== 2 || beat_total !== 32'(exp_beats) || got[0] !== pat(32'hB000)) begin n_fail++; $display("FAIL after_reset: got %0d beats total %0d want 2 2", got.size(), beat_total); end
  endtask
  task automatic test_back_to_back;
    int n, bad, el;
    bit lerr;
    logic [31:0] a, l;
    for (int k = 0; k < 10; k++) begin
      rv_rand = k[0];
      a = {16'(k + 16'h0100), 4'($urandom_range(0, 15)), 12'(8 * $urandom_range(0, 511))};
      if ($urandom_range(0, 7) == 0) a[2] = 1'b1;
      l = {27'($urandom), 5'($urandom_range(0, 31))};
      model(a, l, n, lerr);
      if (lerr) exp_err[2] = 1'b1;
      run_cmd(a, l, -1);
      exp_beats += n;
      el = n == 0 ? 1 : last_cyc - acc_cyc + 1;
      bad = 0;
      foreach (got[i]) if (got[i] !== pat(a + 32'(8 * i))) bad++;
      n_chk++; if (ridle_after !== 1'b0) begin n_fail++; $display("FAIL t6_ridle_drop k%0d: got %b want 0", k, ridle_after); end
      n_chk++; if (ar_cnt !== (n > 0 ? 1 : 0) || got.size() !== n || bad !== 0) begin n_fail++; $display("FAIL t6_xfer k%0d %h len %0d: got ar %0d beats %0d bad %0d want %0d beats", k, a, l[4:0], ar_cnt, got.size(), bad, n); end
      n_chk++; if (beat_total !== 32'(exp_beats) || err_flags !== exp_err) begin n_fail++; $display("FAIL t6_stats k%0d: got %0d/%b want %0d/%b", k, beat_total, err_flags, exp_beats, exp_err); end
      n_chk++; if (lat_cycles !== 32'(el) || low_cnt !== el + 1) begin n_fail++; $display("FAIL t6_timing k%0d: got lat %0d low %0d want %0d %0d", k, lat_cycles, low_cnt, el, el + 1); end
    end
    rv_rand = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_len_err;
    test_resp_last;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
